// File: rtl/te_bthb_mp_fifo.sv
// te_bthb_mp_fifo: multi-port branch target history buffer for the trace encoder.
// Up to WR_PORTS entries enter per cycle. Valid lanes are compacted in lane order.
// The oldest RD_PORTS entries are presented combinationally to the packet builders.
// A push beat is admitted whole or dropped whole. The first dropped beat raises a
// sticky overflow flag, and that flag blocks all pushes until ovf_ack_i.
// Optional feature macro: TE_BTHB_TSTAMP_EN (adds tstamp_i and a per-entry timestamp).
//
// Handshake: rd_vld_o[j] means the entry at head+j is valid on rd_pkt_o lane j.
// The consumer reports how many head entries it took via rd_pop_i. That count must
// not exceed the number of valid read lanes, and it takes effect at the next edge.
// There is no write-side ready: admission status is reported through ovf_o/ovf_pend_o.
//
// Flat entry layout, LSB first: BTHBPkt_s, then Timestamp when the macro is defined.
// That layout is BTHBTstampPkt_s = {Timestamp[TSTAMP_W-1:0], BTHBPkt_s}.

package te_bthb_pkg;
  typedef struct packed {
    logic [1:0]  BrType;
    logic [31:0] VaHi;
    logic [31:0] VaLo;
  } BTHBPkt_s;

  localparam int PKT_W = $bits(BTHBPkt_s);
endpackage

module te_bthb_mp_fifo #(
  parameter int DEPTH    = 10,
  parameter int WR_PORTS = 6,
  parameter int RD_PORTS = 2,
  parameter int TSTAMP_W = 64,
  localparam int PKT_W = te_bthb_pkg::PKT_W,
`ifdef TE_BTHB_TSTAMP_EN
  localparam int ENT_W = PKT_W + TSTAMP_W,
`else
  localparam int ENT_W = PKT_W,
`endif
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int POP_W = $clog2(RD_PORTS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WR_PORTS-1:0]       wr_vld_i,
  input  logic [WR_PORTS*PKT_W-1:0] wr_pkt_i,
`ifdef TE_BTHB_TSTAMP_EN
  input  logic [TSTAMP_W-1:0]       tstamp_i,
`endif
  output logic [RD_PORTS-1:0]       rd_vld_o,
  output logic [RD_PORTS*ENT_W-1:0] rd_pkt_o,
  input  logic [POP_W-1:0]          rd_pop_i,
  input  logic                      flush_i,
  output logic [CW-1:0]             count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      ovf_o,
  output logic                      ovf_pend_o,
  input  logic                      ovf_ack_i
);

  // Pointer width, and a sum width large enough to hold ptr + offset below 2*DEPTH.
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW  = CW + 1;
  localparam int NPW = $clog2(WR_PORTS + 1);

  logic [ENT_W-1:0] mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          ovf_q;
  logic          ovf_pend;

  logic [NPW-1:0]   n_push;
  logic [PW-1:0]    lane_addr [WR_PORTS];
  logic [ENT_W-1:0] lane_ent  [WR_PORTS];
  logic [CW-1:0]    free_slots;
  logic             beat_fits;
  logic             push_ok;
  logic             rej_new;

  // Modulo-DEPTH add. Any depth is allowed, so wrap-around is a single conditional subtract.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input logic [SW-1:0] off);
    logic [SW-1:0] sum;
    sum = SW'(base) + off;
    if (sum >= SW'(DEPTH)) sum = sum - SW'(DEPTH);
    return sum[PW-1:0];
  endfunction

  // Compact the valid lanes. Each valid lane lands at wr_ptr plus the count of valid lanes below it.
  always_comb begin
    n_push = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      lane_addr[i] = wrap_add(wr_ptr, SW'(n_push));
`ifdef TE_BTHB_TSTAMP_EN
      lane_ent[i]  = {tstamp_i, wr_pkt_i[i*PKT_W +: PKT_W]};
`else
      lane_ent[i]  = wr_pkt_i[i*PKT_W +: PKT_W];
`endif
      n_push = n_push + NPW'(wr_vld_i[i]);
    end
  end

  // Admission is decided on start-of-cycle occupancy, so same-cycle pops never make room.
  always_comb begin
    free_slots = CW'(DEPTH) - count;
    beat_fits  = (SW'(n_push) <= SW'(free_slots));
    push_ok    = !flush_i && !ovf_pend && (n_push != '0) && beat_fits;
    rej_new    = !flush_i && !ovf_pend && !beat_fits;
  end

  // Storage write. The array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      for (int i = 0; i < WR_PORTS; i++) begin
        if (wr_vld_i[i]) mem[lane_addr[i]] <= lane_ent[i];
      end
    end
  end

  // Pointers, occupancy and overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ovf_q    <= 1'b0;
      ovf_pend <= 1'b0;
    end else begin
      ovf_q <= rej_new;
      if (rej_new) begin
        ovf_pend <= 1'b1;
      end else if (ovf_ack_i) begin
        ovf_pend <= 1'b0;
      end
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        rd_ptr <= wrap_add(rd_ptr, SW'(rd_pop_i));
        if (push_ok) wr_ptr <= wrap_add(wr_ptr, SW'(n_push));
        count <= count - CW'(rd_pop_i) + (push_ok ? CW'(n_push) : CW'(0));
      end
    end
  end

  // Head window: read lane j shows the entry at rd_ptr+j, with no bypass of same-cycle writes.
  always_comb begin
    rd_vld_o = '0;
    rd_pkt_o = '0;
    for (int j = 0; j < RD_PORTS; j++) begin
      rd_vld_o[j]                 = (count > CW'(j));
      rd_pkt_o[j*ENT_W +: ENT_W]  = mem[wrap_add(rd_ptr, SW'(j))];
    end
  end

  // Status outputs.
  always_comb begin
    count_o    = count;
    full_o     = (count == CW'(DEPTH));
    empty_o    = (count == '0);
    ovf_o      = ovf_q;
    ovf_pend_o = ovf_pend;
  end

  // Guard against illegal pops and an unsupported configuration.
  always @(posedge clk) begin
    assert (DEPTH >= RD_PORTS && DEPTH >= WR_PORTS && TSTAMP_W > 0);
    if (!reset && !flush_i) begin
      assert (SW'(rd_pop_i) <= SW'(count) && SW'(rd_pop_i) <= SW'(RD_PORTS));
    end
  end

endmodule

// File: doc/te_bthb_mp_fifo.md
# te_bthb_mp_fifo

Multi-port branch target history buffer (BTHB) for the trace encoder. It sits between the retire-packet filter and the N-Trace packet builders. Each cycle it accepts up to WR_PORTS BTHB entries, compacted in lane order, and presents the oldest RD_PORTS entries to the packet builders. It is the parametrised successor of the fixed 10-entry, 6-write, 2-read BTHB. New behaviour in this generation:
- non-power-of-two depth;
- all-or-nothing push admission;
- sticky overflow reporting that drives RESTART_FIFO_OVERFLOW sync;
- optional per-entry timestamp.

## Interface
Parameters:
- DEPTH, 10, entry count; any value ≥ RD_PORTS and ≥ WR_PORTS.
- WR_PORTS, 6, write lanes (RETIRE_WIDTH).
- RD_PORTS, 2, read lanes (NUM_BLOCKS).
- TSTAMP_W, 64, timestamp width (only used with TE_BTHB_TSTAMP_EN).

Entry type: BTHBPkt_s, or BTHBTstampPkt_s with TE_BTHB_TSTAMP_EN. CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- wr_vld_i  in  WR_PORTS  per-lane valid; lanes may be sparse.
- wr_pkt_i  in  WR_PORTS×BTHBPkt_s  write entries.
- tstamp_i  in  TSTAMP_W  current time (macro only).
- rd_vld_o  out  RD_PORTS  rd_vld_o[j] = (count_o > j).
- rd_pkt_o  out  RD_PORTS×entry  rd_pkt_o[j] = entry at head+j.
- rd_pop_i  in  $clog2(RD_PORTS+1)  number of head entries consumed this cycle.
- flush_i  in  1  discard all contents.
- count_o  out  CW  occupancy.
- full_o / empty_o  out  1  count_o==DEPTH / count_o==0.
- ovf_o  out  1  one-cycle pulse when a push beat is dropped.
- ovf_pend_o  out  1  sticky overflow flag.
- ovf_ack_i  in  1  clears ovf_pend_o.

## Operation
- Storage: DEPTH-entry register array, with rd_ptr/wr_ptr in 0..DEPTH-1.
- Pointer wrap: ptr+n ≥ DEPTH subtracts DEPTH. There is no power-of-two masking.
- Push demand: n_push = popcount(wr_vld_i).
- Admission uses start-of-cycle occupancy: accept iff n_push ≤ DEPTH − count_o. Same-cycle pops do not create space.
- Accepted beat: valid lanes are written in ascending lane index to wr_ptr, wr_ptr+1, … (mod DEPTH). wr_ptr += n_push.
- Rejected beat (n_push > free): the whole beat is dropped, and nothing is partially written.
  - ovf_o pulses.
  - ovf_pend_o is set.
- While ovf_pend_o=1, every push beat is dropped, whatever the free space. This preserves the lost-history boundary until the encoder issues RESTART_FIFO_OVERFLOW sync and asserts ovf_ack_i.
  - A beat dropped in this state does not pulse ovf_o.
- ovf_ack_i clears ovf_pend_o at the next edge. A push in the ack cycle is still dropped.
- Pop: rd_ptr += rd_pop_i and count decrements. rd_pop_i > count_o or rd_pop_i > RD_PORTS is illegal; simulation asserts.
- Simultaneous push and pop: count_next = count − rd_pop_i + (accepted ? n_push : 0).
- flush_i:
  - rd_ptr = wr_ptr = count = 0.
  - Pushes and pops in the same cycle are ignored.
  - ovf_pend_o is unchanged.
- n_push=0 is never an overflow.

## Timing
- Reset (synchronous, active-high): pointers 0, count_o 0, empty_o 1, full_o 0, rd_vld_o 0, ovf_o 0, ovf_pend_o 0. rd_pkt_o is don't-care while invalid; storage is not reset.
- Write-to-read latency: 1 cycle. An entry pushed at edge N is visible on rd_pkt_o after edge N.
- Read outputs are combinational from storage and rd_ptr. There is no read bypass of same-cycle writes.
- Pop takes effect at the clock edge; the next entries appear in the following cycle.
- ovf_o is registered: it is high in the cycle after the rejected beat.
- ovf_pend_o rises in that same cycle.
- Reset mid-operation overrides flush, push, pop and ack.

## Configuration
- TE_BTHB_TSTAMP_EN defined:
  - entries are BTHBTstampPkt_s;
  - the tstamp_i value in the push cycle is stored in every lane of the beat;
  - rd_pkt_o carries Timestamp.
- Undefined:
  - tstamp_i port absent;
  - entries are BTHBPkt_s;
  - no timestamp storage.

## Test plan
- Reset, then push lanes {0,2,5} with VaLo 0x10/0x20/0x30 → next cycle count_o=3, rd_pkt_o[0].VaLo=0x10, rd_pkt_o[1].VaLo=0x20.
- DEPTH=10: fill 8, then push 3 → beat dropped, count_o stays 8, ovf_o pulses 1 cycle, ovf_pend_o=1. Pop 2, then push 1 → still dropped. ovf_ack_i, then push 1 → count_o=7.
- Wrap: cycle 7 push/pop through pointer 9→0 over 30 cycles at DEPTH=10 → FIFO order preserved and scoreboard-matched, count never exceeds 10.
- count_o=9, pop 2 and push 3 in one cycle → dropped (3 > free 1), count_o=7. The same case with push 1 is accepted, count_o=8.
- flush_i with count_o=6 plus a concurrent push of 2 → count_o=0, empty_o=1, ovf_pend_o unchanged.
- With TE_BTHB_TSTAMP_EN: tstamp_i=0x1234 on a 2-lane push → both entries read Timestamp=0x1234. Without the macro, the block compiles with no tstamp_i port.
